// File: rtl/energy_sample_sequencer.sv
// rtl/energy_sample_sequencer.sv - round-robin converter sample scheduler (optional OVP_ALARM_EN)
module energy_sample_sequencer #(
    parameter int NUM_CH     = 4,
    parameter int SETTLE_CYC = 3,
    parameter int DATA_W     = 8,
    parameter int PER_W      = 8,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [NUM_CH-1:0] ch_req,
    input  logic [PER_W-1:0]  period,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              sample_ready,
    input  logic [DATA_W-1:0] ovp_thresh,
    input  logic              ovp_clr,
    output logic [CH_W-1:0]   ch_sel,
    output logic [DATA_W-1:0] sample_data,
    output logic [CH_W-1:0]   sample_ch,
    output logic              sample_valid,
    output logic              busy,
    output logic [7:0]        overrun_cnt,
    output logic              ovp_flag
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_PRESENT} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [PER_W-1:0]  r_tick_cnt;
    logic [3:0]        r_settle_cnt;
    logic [CH_W-1:0]   r_last_grant;
    logic [CH_W-1:0]   r_ch_sel;
    logic [CH_W-1:0]   r_sample_ch;
    logic [DATA_W-1:0] r_sample_data;
    logic              r_sample_valid;
    logic [7:0]        r_overrun_cnt;
    logic              r_ovp_flag;
    logic [CH_W-1:0]   w_grant;
    logic [CH_W:0]     w_idx;
    logic              w_tick;
    logic              w_start;
    logic              w_transfer;

    assign w_tick     = (r_tick_cnt == period);
    assign w_start    = (r_state == S_IDLE) && w_tick && (|ch_req);
    assign w_transfer = (r_state == S_PRESENT) && r_sample_valid && sample_ready;

    // Walk candidates farthest-first so the nearest requester after last_grant wins.
    always_comb begin
        w_grant = r_last_grant;
        w_idx   = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            w_idx = {1'b0, r_last_grant} + (CH_W+1)'(i);
            if (w_idx >= (CH_W+1)'(NUM_CH)) begin
                w_idx = w_idx - (CH_W+1)'(NUM_CH);
            end
            if (ch_req[w_idx[CH_W-1:0]]) begin
                w_grant = w_idx[CH_W-1:0];
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:    if (w_start) w_next_state = S_SETTLE;
            S_SETTLE:  if (r_settle_cnt == 4'd0) w_next_state = S_CAPTURE;
            S_CAPTURE: w_next_state = S_PRESENT;
            S_PRESENT: if (w_transfer) w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else if (ena) begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt     <= '0;
            r_settle_cnt   <= '0;
            r_last_grant   <= CH_W'(NUM_CH - 1);
            r_ch_sel       <= '0;
            r_sample_ch    <= '0;
            r_sample_data  <= '0;
            r_sample_valid <= 1'b0;
            r_overrun_cnt  <= '0;
        end else if (ena) begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            // Ticks that land while a sample is in flight are lost; count them.
            if (w_tick && (r_state != S_IDLE) && (r_overrun_cnt != 8'hFF)) begin
                r_overrun_cnt <= r_overrun_cnt + 8'd1;
            end
            if (w_start) begin
                r_ch_sel     <= w_grant;
                r_last_grant <= w_grant;
                r_settle_cnt <= 4'(SETTLE_CYC);
            end
            if ((r_state == S_SETTLE) && (r_settle_cnt != 4'd0)) begin
                r_settle_cnt <= r_settle_cnt - 4'd1;
            end
            if (r_state == S_CAPTURE) begin
                r_sample_data  <= adc_data;
                r_sample_ch    <= r_ch_sel;
                r_sample_valid <= 1'b1;
            end
            if (w_transfer) begin
                r_sample_valid <= 1'b0;
            end
        end
    end

`ifdef OVP_ALARM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovp_flag <= 1'b0;
        end else if (ena) begin
            if ((r_state == S_CAPTURE) && (adc_data > ovp_thresh)) begin
                r_ovp_flag <= 1'b1;
            end else if (ovp_clr) begin
                r_ovp_flag <= 1'b0;
            end
        end
    end
`else
    logic w_unused_ovp;
    assign w_unused_ovp = ^{ovp_thresh, ovp_clr};
    assign r_ovp_flag   = 1'b0;
`endif

    assign ch_sel       = r_ch_sel;
    assign sample_data  = r_sample_data;
    assign sample_ch    = r_sample_ch;
    assign sample_valid = r_sample_valid;
    assign busy         = (r_state != S_IDLE);
    assign overrun_cnt  = r_overrun_cnt;
    assign ovp_flag     = r_ovp_flag;

endmodule

// File: tb/tb_energy_sample_sequencer.sv
// tb/tb_energy_sample_sequencer.sv - randomized self-checking bench for energy_sample_sequencer
module tb_energy_sample_sequencer;

    localparam int NUM_CH = 4;
    localparam int SETTLE = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic [3:0]  ch_req = '0;
    logic [7:0]  period = '0;
    logic [7:0]  adc_data = '0;
    logic        sample_ready = 1'b0;
    logic [7:0]  ovp_thresh = '0;
    logic        ovp_clr = 1'b0;
    logic [1:0]  ch_sel;
    logic [7:0]  sample_data;
    logic [1:0]  sample_ch;
    logic        sample_valid;
    logic        busy;
    logic [7:0]  overrun_cnt;
    logic        ovp_flag;

    always #5 clk = ~clk;

    energy_sample_sequencer #(.NUM_CH(NUM_CH), .SETTLE_CYC(SETTLE), .DATA_W(8), .PER_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ch_req(ch_req), .period(period),
        .adc_data(adc_data), .sample_ready(sample_ready), .ovp_thresh(ovp_thresh),
        .ovp_clr(ovp_clr), .ch_sel(ch_sel), .sample_data(sample_data), .sample_ch(sample_ch),
        .sample_valid(sample_valid), .busy(busy), .overrun_cnt(overrun_cnt), .ovp_flag(ovp_flag)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: a sample in flight is a countdown to its capture edge, then a pending valid.
    logic [7:0] m_tick;
    int         m_last, m_sel, m_ch, m_cd, m_ovr;
    logic [7:0] m_data;
    bit         m_valid, m_busy, m_ovp;

    task automatic model_reset();
        m_tick = '0; m_last = NUM_CH - 1; m_sel = 0; m_ch = 0; m_cd = 0; m_ovr = 0;
        m_data = '0; m_valid = 0; m_busy = 0; m_ovp = 0;
    endtask

    task automatic model_edge();
        bit tick, cap;
        int g, c;
        logic [3:0] sh;
        if (!ena) return;
        cap  = 0;
        tick = (m_tick == period);
        m_tick = tick ? 8'd0 : m_tick + 8'd1;
        if (!m_busy) begin
            if (tick && ch_req != 0) begin
                g = -1;
                for (int i = 1; i <= NUM_CH; i++) begin
                    c  = (m_last + i) % NUM_CH;
                    sh = ch_req >> c;
                    if (g < 0 && sh[0]) g = c;
                end
                m_sel = g; m_last = g; m_busy = 1; m_cd = SETTLE + 2;
            end
        end else begin
            if (tick && m_ovr < 255) m_ovr++;
            if (!m_valid) begin
                m_cd--;
                if (m_cd == 0) begin
                    m_data = adc_data; m_ch = m_sel; m_valid = 1; cap = 1;
                end
            end else if (sample_ready) begin
                m_valid = 0; m_busy = 0;
            end
        end
`ifdef OVP_ALARM_EN
        if (cap && adc_data > ovp_thresh) m_ovp = 1;
        else if (ovp_clr) m_ovp = 0;
`endif
    endtask

    task automatic compare_all();
        check_eq("ch_sel", 32'(ch_sel), 32'(m_sel));
        check_eq("sample_data", 32'(sample_data), 32'(m_data));
        check_eq("sample_ch", 32'(sample_ch), 32'(m_ch));
        check_eq("sample_valid", 32'(sample_valid), 32'(m_valid));
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("overrun_cnt", 32'(overrun_cnt), 32'(m_ovr));
        check_eq("ovp_flag", 32'(ovp_flag), 32'(m_ovp));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_until_valid(input int max, input string tag, output int n);
        n = 0;
        while (!sample_valid && n < max) begin
            cycle();
            n++;
        end
        if (!sample_valid) check_eq({tag, "_timeout"}, 32'(sample_valid), 32'd1);
    endtask

    int first, n, guard;
    int exp_seq[6] = '{0, 1, 3, 0, 1, 3};
    int got_seq[$];
    bit prev_valid;

    initial begin
        // Test 1: first tick on 10th edge, valid 5 edges later
        ena = 1; ch_req = 4'b0001; period = 8'd9; adc_data = 8'hA5; sample_ready = 1;
        do_reset();
        first = 0;
        for (int i = 1; i <= 30; i++) begin
            cycle();
            if (sample_valid && first == 0) first = i;
        end
        check_eq("t1_latency", 32'(first), 32'd15);

        // Test 2: round-robin grant order
        ch_req = 4'b1011; period = 8'd15;
        do_reset();
        prev_valid = 0; guard = 0;
        while (got_seq.size() < 6 && guard < 300) begin
            adc_data = 8'($urandom);
            cycle();
            if (sample_valid && !prev_valid) got_seq.push_back(int'(sample_ch));
            prev_valid = sample_valid;
            guard++;
        end
        check_eq("t2_count", 32'(got_seq.size()), 32'd6);
        for (int i = 0; i < 6 && i < got_seq.size(); i++) check_eq("t2_grant", 32'(got_seq[i]), 32'(exp_seq[i]));
        check_eq("t2_overrun", 32'(overrun_cnt), 32'd0);

        // Test 3: backpressure with period 0
        ch_req = 4'b0001; period = 8'd0; sample_ready = 0; adc_data = 8'h3C;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (i > 6) adc_data = 8'($urandom);
        end
        check_eq("t3_held_valid", 32'(sample_valid), 32'd1);
        check_eq("t3_held_data", 32'(sample_data), 32'h3C);
        check_eq("t3_ovr_ge14", 32'(overrun_cnt >= 8'd14), 32'd1);
        sample_ready = 1;
        cycle();
        check_eq("t3_idle", 32'(busy), 32'd0);

        // Test 4: freeze mid-settle
        ch_req = 4'b0010; period = 8'd4; sample_ready = 1;
        do_reset();
        guard = 0;
        while (!busy && guard < 20) begin cycle(); guard++; end
        check_eq("t4_busy", 32'(busy), 32'd1);
        cycle();
        ena = 0;
        for (int i = 0; i < 7; i++) cycle();
        ena = 1;
        run_until_valid(20, "t4", n);
        check_eq("t4_settle_len", 32'(1 + n), 32'(SETTLE + 2));

        // Test 5: reset during PRESENT
        sample_ready = 0; ch_req = 4'b0100; period = 8'd2;
        cycle();
        run_until_valid(40, "t5a", n);
        rst_n = 1'b0;
        #1;
        check_eq("t5_valid_rst", 32'(sample_valid), 32'd0);
        check_eq("t5_data_rst", 32'(sample_data), 32'd0);
        check_eq("t5_ovr_rst", 32'(overrun_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        ch_req = 4'b1111; period = 8'd0; sample_ready = 1;
        run_until_valid(20, "t5b", n);
        check_eq("t5_first_ch", 32'(sample_ch), 32'd0);

`ifdef OVP_ALARM_EN
        // Test 6: over-voltage alarm
        ovp_thresh = 8'hC0; adc_data = 8'hC1; ch_req = 4'b0001; period = 8'd3; sample_ready = 0;
        do_reset();
        run_until_valid(30, "t6a", n);
        check_eq("t6_set", 32'(ovp_flag), 32'd1);
        sample_ready = 1; ovp_clr = 1;
        cycle();
        ovp_clr = 0; sample_ready = 0; adc_data = 8'hC0;
        check_eq("t6_clr", 32'(ovp_flag), 32'd0);
        run_until_valid(30, "t6b", n);
        check_eq("t6_equal", 32'(ovp_flag), 32'd0);
        sample_ready = 1;
        cycle();
        sample_ready = 0; adc_data = 8'hFF; ovp_clr = 1;
        run_until_valid(30, "t6c", n);
        check_eq("t6_set_wins", 32'(ovp_flag), 32'd1);
        ovp_clr = 0;
`endif

        // Randomized phase
        period = 8'd5;
        for (int i = 0; i < 2500; i++) begin
            ena          = ($urandom_range(0, 9) != 0);
            ch_req       = 4'($urandom);
            adc_data     = 8'($urandom);
            sample_ready = ($urandom_range(0, 2) != 0);
            ovp_clr      = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 49) == 0) period = 8'($urandom_range(0, 12));
            if ($urandom_range(0, 99) == 0) ovp_thresh = 8'($urandom);
            if ($urandom_range(0, 399) == 0) do_reset();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/energy_sample_sequencer.md
Name: energy_sample_sequencer

Overview:
Scheduler for the shared converter input path. Periodically picks one of several requesting energy channels (solar, wind, battery, load) round-robin, drives the external analog mux select, waits a settle time, captures the 8-bit converted voltage and presents it downstream with a valid/ready handshake. It sits between the chip inputs and the data-logging/output logic, gated by the top-level enable.

Parameters:
NUM_CH, 4, number of channels (2..8).
SETTLE_CYC, 3, extra settle cycles after a channel switch (0..15).
DATA_W, 8, sample width.
PER_W, 8, width of the period input.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
ena  input  1  global enable; low freezes the block
ch_req  input  NUM_CH  per-channel sample request (level)
period  input  PER_W  sample period minus one, in enabled cycles
adc_data  input  DATA_W  converted voltage of the currently selected channel
sample_ready  input  1  downstream accepts sample
ovp_thresh  input  DATA_W  over-voltage threshold (used only with OVP_ALARM_EN)
ovp_clr  input  1  clears ovp_flag (used only with OVP_ALARM_EN)
ch_sel  output  clog2(NUM_CH)  analog mux select
sample_data  output  DATA_W  captured sample
sample_ch  output  clog2(NUM_CH)  channel of sample_data
sample_valid  output  1  sample_data/sample_ch valid
busy  output  1  state != IDLE
overrun_cnt  output  8  dropped-tick counter
ovp_flag  output  1  sticky over-voltage alarm

Behaviour:
- One clock domain; reset asynchronous, active-low. All state is held in flops.
- Reset values: ch_sel=0, sample_data=0, sample_ch=0, sample_valid=0, busy=0, overrun_cnt=0, ovp_flag=0, state=IDLE, tick_cnt=0, last_grant=NUM_CH-1 so channel 0 wins first.
- ena=0: no state, counter or output changes; handshakes are not accepted; outputs hold.
- Tick generator: tick_cnt increments on every enabled edge. When tick_cnt==period, a tick event occurs on that edge and tick_cnt returns to 0. Ticks occur every period+1 enabled cycles; period=0 gives a tick every cycle. A period change takes effect at the next compare.
- FSM states: IDLE, SETTLE, CAPTURE, PRESENT.
- IDLE: on a tick with ch_req!=0, grant the first set bit searching from last_grant+1 upward with wrap. Set ch_sel and last_grant to the grant, load settle_cnt=SETTLE_CYC, go to SETTLE. On a tick with ch_req==0, stay in IDLE; this is not an overrun.
- SETTLE: if settle_cnt==0, go to CAPTURE; else decrement. SETTLE lasts SETTLE_CYC+1 cycles.
- CAPTURE: one cycle. Set sample_data<=adc_data, sample_ch<=ch_sel, sample_valid<=1, and go to PRESENT.
- PRESENT: hold outputs stable. A transfer occurs on an enabled edge with sample_valid&&sample_ready; then sample_valid<=0 and the FSM goes to IDLE.
- Latency: sample_valid is high after edge G+SETTLE_CYC+2, where G is the granting edge. adc_data is sampled at that same edge.
- A tick arriving while state!=IDLE is dropped. overrun_cnt increments and saturates at 255.
- A ch_req bit deasserting after grant does not abort the sequence; the sample completes.
- ch_sel holds its last grant in IDLE; there is no mux switching between samples.
- Reset mid-sequence returns all state to reset values immediately; the partial sample is discarded.

Optional Feature:
OVP_ALARM_EN.
- Defined: at the CAPTURE edge, if adc_data > ovp_thresh (unsigned), ovp_flag<=1 (sticky). ovp_clr=1 on an enabled edge clears ovp_flag. If set and clear happen on the same edge, set wins.
- Undefined: ovp_flag is tied to 0; ovp_thresh and ovp_clr are ignored. The port list is unchanged.

Test Plan:
1. Reset, ena=1, ch_req=4'b0001, period=9, SETTLE_CYC=3, adc_data=8'hA5, sample_ready=1 -> first tick at the 10th edge; sample_valid high 5 edges later with sample_data=A5, sample_ch=0; busy drops after the transfer.
2. ch_req=4'b1011, period=15, ready=1 -> successive grants 0,1,3,0,1,3; ch_sel matches each sample_ch; overrun_cnt=0.
3. period=0, ch_req=4'b0001, sample_ready=0 for 20 cycles -> one sample held stable with sample_valid=1; overrun_cnt counts every dropped tick (>=14); raise ready -> one transfer, then return to IDLE.
4. ena=0 mid-SETTLE for 7 cycles -> all outputs and counters frozen; on ena=1 the sequence resumes and the total SETTLE length (enabled cycles) is still SETTLE_CYC+1.
5. Deassert rst_n during PRESENT -> sample_valid=0, sample_data=0, overrun_cnt=0 immediately; the next grant is channel 0.
6. OVP_ALARM_EN, ovp_thresh=8'hC0, adc_data=8'hC1 -> ovp_flag=1 after capture; adc_data=8'hC0 with ovp_clr pulse -> ovp_flag=0; capture of 8'hFF concurrent with ovp_clr -> ovp_flag=1.
